// File: rtl/monitor_verdict_serializer.sv
// Snapshots active monitor outputs into a FIFO and serializes each as header + per-stream data beats.
// Header appears two cycles after capture; valid/ready output holds beats under stall, full FIFO drops snapshots.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still take a push
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

module monitor_verdict_serializer #(
  parameter int N_OUT = 14,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_OUT*64-1:0]  out_data,
  input  logic [N_OUT-1:0]     out_aktv,
  output logic [63:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 overflow,
  output logic [15:0]          drop_cnt
);
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int EW = 32 + N_OUT + 64 * N_OUT;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic [31:0]         ts;
  logic                snap_req, accept, drop, pop;
  logic                full, empty;
  logic [CW-1:0]       count;
  logic [EW-1:0]       head;
  logic [31:0]         head_ts;
  logic [N_OUT-1:0]    head_mask;
  logic [N_OUT*64-1:0] head_data;
  logic [IW-1:0]       lo_idx, nx_idx;
  logic                has_nx;
  logic [63:0]         hdr_word, sel_word;

  assign snap_req = en & (|out_aktv);
  assign accept   = snap_req & (~full | pop);
  assign drop     = snap_req & ~accept;

  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (snap_req),
    .wdata ({ts, out_aktv, out_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_ts   = head[EW-1 -: 32];
  assign head_mask = head[64*N_OUT +: N_OUT];
  assign head_data = head[N_OUT*64-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts       <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en) ts <= ts + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Descending scan leaves the lowest qualifying bit as the winner.
  always_comb begin
    lo_idx   = '0;
    nx_idx   = '0;
    has_nx   = 1'b0;
    sel_word = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (head_mask[i]) lo_idx = IW'(i);
      if (head_mask[i] && (i > int'(idx))) begin
        nx_idx = IW'(i);
        has_nx = 1'b1;
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (idx == IW'(i)) sel_word = head_data[64*i +: 64];
    end
    hdr_word              = '0;
    hdr_word[63:32]       = head_ts;
    hdr_word[N_OUT-1:0]   = head_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = '0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nx = HDR;
      end
      HDR: begin
        m_valid = 1'b1;
        m_data  = hdr_word;
        if (m_ready) begin
          state_nx = DATA;
          idx_nx   = lo_idx;
        end
      end
      DATA: begin
        m_valid = 1'b1;
        m_data  = sel_word;
        m_last  = ~has_nx;
        if (m_ready) begin
          if (has_nx) begin
            idx_nx = nx_idx;
          end else begin
            pop = 1'b1;
            // a snapshot landing in the pop cycle keeps the stream back-to-back
            state_nx = ((count > CW'(1)) || accept) ? HDR : IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_monitor_verdict_serializer.sv
// Directed bench for monitor_verdict_serializer: single record, stall, overflow, full+pop, gating, reset.
module tb_monitor_verdict_serializer;
  localparam int N_OUT = 14;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 m_ready = 1'b0;
  logic [N_OUT*64-1:0]  out_data = '0;
  logic [N_OUT-1:0]     out_aktv = '0;
  logic [63:0]          m_data;
  logic                 m_valid, m_last, overflow;
  logic [15:0]          drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  monitor_verdict_serializer #(.N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .out_data (out_data),
    .out_aktv (out_aktv),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    en       = 1'b0;
    m_ready  = 1'b0;
    out_aktv = '0;
    out_data = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic beat(input string tag, input logic [63:0] data, input logic last);
    check({tag, "_vld"},  64'(m_valid), 64'd1);
    check({tag, "_data"}, m_data, data);
    check({tag, "_last"}, 64'(m_last), 64'(last));
  endtask

  function automatic logic [63:0] hdr(input logic [31:0] t, input logic [N_OUT-1:0] mask);
    return {t, 18'h0, mask};
  endfunction

  logic [31:0] exp_ts [4];
  logic [63:0] exp_dat [4];

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_vld",  64'(m_valid),  64'd0);
    check("rst_last", 64'(m_last),   64'd0);
    check("rst_data", m_data,        64'd0);
    check("rst_ovf",  64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    tick();

    // single record at ts=10, streams 0 and 2
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    repeat (10) tick();
    out_aktv = 14'b101;
    out_data[0 +: 64]   = 64'd7;
    out_data[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    out_aktv = '0;
    check("t1_gap_vld", 64'(m_valid), 64'd0);
    tick();
    beat("t1_hdr", hdr(32'd10, 14'h5), 1'b0);
    tick();
    beat("t1_d0", 64'd7, 1'b0);
    tick();
    beat("t1_d2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    tick();
    check("t1_end_vld", 64'(m_valid), 64'd0);

    // backpressure: header held for 5 stalled cycles
    do_reset();
    en = 1'b1;
    repeat (10) tick();
    out_aktv = 14'b101;
    out_data[0 +: 64]   = 64'd7;
    out_data[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    out_aktv = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      beat("t2_stall", hdr(32'd10, 14'h5), 1'b0);
      tick();
    end
    m_ready = 1'b1;
    beat("t2_hdr", hdr(32'd10, 14'h5), 1'b0);
    tick();
    beat("t2_d0", 64'd7, 1'b0);
    tick();
    beat("t2_d2", 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    tick();
    check("t2_end_vld", 64'(m_valid), 64'd0);

    // overflow: 6 captures into a depth-4 FIFO with no drain
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      out_aktv = 14'h1;
      out_data[0 +: 64] = 64'(100 + k);
      tick();
    end
    out_aktv = '0;
    check("t3_ovf",  64'(overflow), 64'd1);
    check("t3_drop", 64'(drop_cnt), 64'd2);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      beat("t3_hdr", hdr(32'(k), 14'h1), 1'b0);
      tick();
      beat("t3_dat", 64'(100 + k), 1'b1);
      tick();
    end
    check("t3_end_vld", 64'(m_valid), 64'd0);

    // full FIFO plus pop in the same cycle accepts the snapshot
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      out_aktv = 14'h1;
      out_data[0 +: 64] = 64'(200 + k);
      tick();
    end
    out_aktv = '0;
    m_ready = 1'b1;
    beat("t4_hdr0", hdr(32'd0, 14'h1), 1'b0);
    tick();
    beat("t4_dat0", 64'd200, 1'b1);
    out_aktv = 14'h1;
    out_data[0 +: 64] = 64'd555;
    tick();
    out_aktv = '0;
    check("t4_drop", 64'(drop_cnt), 64'd0);
    check("t4_ovf",  64'(overflow), 64'd0);
    exp_ts  = '{32'd1, 32'd2, 32'd3, 32'd5};
    exp_dat = '{64'd201, 64'd202, 64'd203, 64'd555};
    for (int j = 0; j < 4; j++) begin
      beat("t4_hdr", hdr(exp_ts[j], 14'h1), 1'b0);
      tick();
      beat("t4_dat", exp_dat[j], 1'b1);
      tick();
    end
    check("t4_end_vld", 64'(m_valid), 64'd0);

    // enable gating: ts frozen at 3 while en=0
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    out_aktv = 14'h1;
    out_data[0 +: 64] = 64'd42;
    for (int k = 0; k < 10; k++) begin
      check("t5_gated_vld", 64'(m_valid), 64'd0);
      tick();
    end
    en = 1'b1;
    check("t5_cap_vld", 64'(m_valid), 64'd0);
    tick();
    out_aktv = '0;
    check("t5_gap_vld", 64'(m_valid), 64'd0);
    tick();
    beat("t5_hdr", hdr(32'd3, 14'h1), 1'b0);
    tick();
    beat("t5_dat", 64'd42, 1'b1);
    tick();

    // reset after header of a 14-stream record; capture on first cycle after release
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    out_aktv = 14'h3FFF;
    for (int i = 0; i < N_OUT; i++) out_data[64*i +: 64] = 64'(1000 + i);
    tick();
    out_aktv = '0;
    tick();
    beat("t6_hdr", hdr(32'd0, 14'h3FFF), 1'b0);
    tick();
    beat("t6_d0", 64'd1000, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_rst_vld",  64'(m_valid), 64'd0);
    check("t6_rst_data", m_data, 64'd0);
    tick();
    rst = 1'b1;
    out_aktv = 14'b10;
    out_data[64 +: 64] = 64'd77;
    tick();
    out_aktv = '0;
    check("t6_gap_vld", 64'(m_valid), 64'd0);
    tick();
    beat("t6_new_hdr", hdr(32'd0, 14'h2), 1'b0);
    tick();
    beat("t6_new_dat", 64'd77, 1'b1);
    tick();
    check("t6_end_vld", 64'(m_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/monitor_verdict_serializer.md
MONITOR_VERDICT_SERIALIZER -- requirements
Module: monitor_verdict_serializer

Interface
REQ-001 Parameter N_OUT, default 14, SHALL set the number of monitor output streams; legal range 1..32.
REQ-002 Parameter DEPTH, default 4, SHALL set the snapshot FIFO depth in entries; legal values 2, 4, 8 or 16.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-low (0 = reset asserted).
REQ-005 en  in  1  SHALL be the global enable, same meaning as the monitor's en.
REQ-006 out_data  in  N_OUT*64  SHALL carry the monitor outputs, signed 64-bit each; stream i occupies bits [64*i+63:64*i].
REQ-007 out_aktv  in  N_OUT  SHALL carry the per-stream active flags; bit i qualifies stream i for the current cycle.
REQ-008 m_data  out  64  SHALL carry the serialized word.
REQ-009 m_valid  out  1  SHALL indicate that m_data is valid.
REQ-010 m_ready  in  1  SHALL be the downstream acceptance signal; a beat transfers when m_valid and m_ready are both 1.
REQ-011 m_last  out  1  SHALL mark the final beat of a record.
REQ-012 overflow  out  1  SHALL be a sticky flag indicating that at least one snapshot was dropped.
REQ-013 drop_cnt  out  16  SHALL count dropped snapshots.

Function
REQ-014 A 32-bit cycle counter ts SHALL increment by 1 on every cycle with en=1, wrap from 0xFFFFFFFF to 0, and hold when en=0.
REQ-015 A snapshot is requested when en=1 and |out_aktv=1; it SHALL store {ts, out_aktv, out_data} as sampled in that cycle.
REQ-016 en=0 or out_aktv=0 SHALL produce no snapshot.
REQ-017 The output side SHALL ignore en; a record already in progress SHALL complete even while en=0.
REQ-018 A record SHALL consist of one header beat followed by one data beat per set mask bit, in ascending stream index; the record length is 1+popcount(mask).
REQ-019 The header beat SHALL be m_data[63:32]=ts, m_data[31:N_OUT]=0, m_data[N_OUT-1:0]=mask.
REQ-020 Each data beat SHALL be the 64-bit value of the corresponding stream, passed through unmodified.
REQ-021 m_last SHALL be 1 only on the final beat of each record; when mask has exactly one bit set, that is the first data beat.
REQ-022 The FSM SHALL have three states.
- IDLE: m_valid=0; goes to HDR when the FIFO is not empty.
- HDR: m_valid=1, header presented; on transfer goes to DATA, with the index pointing at the lowest set mask bit.
- DATA: m_valid=1; on transfer advances to the next set bit; on transfer with m_last=1, pops the entry and goes to HDR if another entry remains, otherwise to IDLE.
REQ-023 Latency: a snapshot captured in cycle t into an empty FIFO with the FSM in IDLE SHALL present its header with m_valid=1 in cycle t+2.
REQ-024 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-025 Throughput: with m_ready held at 1, the block SHALL transfer one beat per cycle, including back-to-back records with no idle cycle between them.
REQ-026 Full FIFO: a snapshot requested while the FIFO is full SHALL be dropped.
- If the same cycle pops the last entry (final beat transfers), the snapshot SHALL be accepted instead.
REQ-027 On each drop, overflow SHALL be set and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-028 Empty FIFO: the block SHALL not issue a pop while the FIFO is empty.
REQ-029 A snapshot requested in the same cycle as a pop SHALL be stored without loss or reordering.
REQ-030 Records SHALL leave in capture order.

Reset
REQ-031 While rst=0, the block SHALL hold these values: m_valid=0, m_last=0, m_data=0, overflow=0, drop_cnt=0, ts=0, FIFO empty, FSM=IDLE.
REQ-032 Reset asserted mid-record SHALL discard the partial record and all queued entries; no beat of them SHALL appear after release.
REQ-033 The first cycle after rst rises SHALL be able to capture a snapshot.

Verification
REQ-034 Single record: after reset release with en=1, set out_aktv=0b101 for 1 cycle at ts=10, streams 0 and 2 = 7 and -3, m_ready=1.
- Required: header {10, mask 0x0005}, then 7, then -3 with m_last=1; three consecutive beats starting 2 cycles later.
REQ-035 Backpressure: as REQ-034, but m_ready=0 for 5 cycles.
- Required: header stays stable and valid; after m_ready rises, the same 3 beats follow; no duplicate or skipped beats.
REQ-036 Overflow: DEPTH=4, m_ready=0, 6 consecutive cycles with out_aktv=1.
- Required: overflow=1, drop_cnt=2; after m_ready=1, exactly 4 records with ts values of the first 4 capture cycles.
REQ-037 Full plus pop: FIFO full, snapshot requested in the same cycle as the final beat of the head record.
- Required: snapshot accepted, drop_cnt unchanged.
REQ-038 Enable gating: en=0 with out_aktv=1 for 10 cycles.
- Required: no snapshot, ts frozen; after en=1, the next capture carries the frozen ts value.
REQ-039 Reset mid-record: assert rst after the header transfer of a 14-active record.
- Required: m_valid=0 immediately; after release, no data beats from the lost record.
